// File: rtl/mem_port_arbiter_if.sv
// CPU / I/O / RAM bundle for the shared LC-3 memory port arbiter.
// slave is the arbiter view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              io_req;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ack;
  logic [DATA_W-1:0] io_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              grant_io;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_we, io_addr, io_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, io_ack, io_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output grant_io
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_we, io_addr, io_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, io_ack, io_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  grant_io
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU / I/O arbiter sequencing fixed-latency LC-3 RAM accesses.
// IDLE grants, BUSY holds the strobe MEM_LAT cycles, RESP pulses the ack.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              gio_q, gio_d;
  logic              last_io_q, last_io_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              cack_q, cack_d;
  logic              iack_q, iack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic              pick_io;

  // I/O wins only when alone, or on a tie when the CPU won last
  assign pick_io = bus.io_req && (!bus.cpu_req || !last_io_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    gio_d     = gio_q;
    last_io_d = last_io_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    crd_d     = crd_q;
    ird_d     = ird_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    cack_d    = 1'b0;
    iack_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.io_req) begin
          state_d   = BUSY;
          cnt_d     = LAT_M1;
          gio_d     = pick_io;
          last_io_d = pick_io;
          we_d      = pick_io ? bus.io_we : bus.cpu_we;
          addr_d    = pick_io ? bus.io_addr : bus.cpu_addr;
          wdata_d   = pick_io ? bus.io_wdata : bus.cpu_wdata;
          rd_d      = !we_d;
          wr_d      = we_d;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          cack_d  = !gio_q;
          iack_d  = gio_q;
          if (!we_q && gio_q)  ird_d = bus.mem_rdata;
          if (!we_q && !gio_q) crd_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = !we_q;
          wr_d  = we_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      gio_q     <= 1'b0;
      last_io_q <= 1'b1;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cack_q    <= 1'b0;
      iack_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      crd_q     <= '0;
      ird_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      gio_q     <= gio_d;
      last_io_q <= last_io_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cack_q    <= cack_d;
      iack_q    <= iack_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      crd_q     <= crd_d;
      ird_q     <= ird_d;
    end
  end

  assign bus.cpu_ack   = cack_q;
  assign bus.io_ack    = iack_q;
  assign bus.cpu_rdata = crd_q;
  assign bus.io_rdata  = ird_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.grant_io  = gio_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 and MEM_LAT=1 instances.
// RAM model returns 16'h1234 at 16'h3000, otherwise addr ^ 16'h5A5A.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  mem_port_arbiter_if b2 ();
  mem_port_arbiter_if b1 ();

  mem_port_arbiter #(.MEM_LAT(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (b2)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  function automatic logic [15:0] ram(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  always_comb b2.mem_rdata = ram(b2.mem_addr);
  always_comb b1.mem_rdata = ram(b1.mem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic no_overlap();
    chk("strobe_excl", 32'(b2.mem_read & b2.mem_write), 0);
    chk("ack_excl", 32'(b2.cpu_ack & b2.io_ack), 0);
  endtask

  task automatic idle_inputs();
    b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = 0; b2.cpu_wdata = 0;
    b2.io_req  = 0; b2.io_we  = 0; b2.io_addr  = 0; b2.io_wdata  = 0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.io_req  = 0; b1.io_we  = 0; b1.io_addr  = 0; b1.io_wdata  = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cack"}, 32'(b2.cpu_ack), 0);
    chk({tag, "_iack"}, 32'(b2.io_ack), 0);
    chk({tag, "_rd"}, 32'(b2.mem_read), 0);
    chk({tag, "_wr"}, 32'(b2.mem_write), 0);
    chk({tag, "_addr"}, 32'(b2.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(b2.mem_wdata), 0);
    chk({tag, "_crd"}, 32'(b2.cpu_rdata), 0);
    chk({tag, "_ird"}, 32'(b2.io_rdata), 0);
    chk({tag, "_gio"}, 32'(b2.grant_io), 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk_zero("rst");
    reset = 1'b0;
    step();

    // CPU read at 16'h3000
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 16'h3000;
    step();
    chk("t1_rd1", 32'(b2.mem_read), 1);
    chk("t1_addr", 32'(b2.mem_addr), 32'h3000);
    chk("t1_gio", 32'(b2.grant_io), 0);
    step();
    chk("t1_rd2", 32'(b2.mem_read), 1);
    chk("t1_ack_early", 32'(b2.cpu_ack), 0);
    step();
    chk("t1_rd3", 32'(b2.mem_read), 0);
    chk("t1_ack", 32'(b2.cpu_ack), 1);
    chk("t1_iack", 32'(b2.io_ack), 0);
    chk("t1_crd", 32'(b2.cpu_rdata), 32'h1234);
    b2.cpu_req = 0;
    step();
    chk("t1_ack_off", 32'(b2.cpu_ack), 0);

    // I/O write
    b2.io_req = 1; b2.io_we = 1;
    b2.io_addr = 16'hFE06; b2.io_wdata = 16'h0041;
    step();
    chk("t2_wr1", 32'(b2.mem_write), 1);
    chk("t2_rd1", 32'(b2.mem_read), 0);
    chk("t2_addr", 32'(b2.mem_addr), 32'hFE06);
    chk("t2_wdata", 32'(b2.mem_wdata), 32'h0041);
    chk("t2_gio", 32'(b2.grant_io), 1);
    step();
    chk("t2_wr2", 32'(b2.mem_write), 1);
    step();
    chk("t2_wr3", 32'(b2.mem_write), 0);
    chk("t2_iack", 32'(b2.io_ack), 1);
    chk("t2_cack", 32'(b2.cpu_ack), 0);
    chk("t2_ird", 32'(b2.io_rdata), 0);
    chk("t2_crd", 32'(b2.cpu_rdata), 32'h1234);
    b2.io_req = 0; b2.io_we = 0;
    step();

    // continuous tie: CPU, I/O, CPU, I/O
    b2.cpu_req = 1; b2.cpu_addr = 16'h0010;
    b2.io_req  = 1; b2.io_addr  = 16'h0020;
    for (int i = 1; i <= 16; i++) begin
      step();
      no_overlap();
      chk($sformatf("t3_cack%0d", i), 32'(b2.cpu_ack),
          32'(i == 3 || i == 11));
      chk($sformatf("t3_iack%0d", i), 32'(b2.io_ack),
          32'(i == 7 || i == 15));
      chk($sformatf("t3_gio%0d", i), 32'(b2.grant_io),
          32'(((i - 1) / 4) % 2));
      if (i == 3) chk("t3_crd", 32'(b2.cpu_rdata), 32'h5A4A);
      if (i == 7) chk("t3_ird", 32'(b2.io_rdata), 32'h5A7A);
    end
    b2.cpu_req = 0; b2.io_req = 0;
    step();

    // I/O request arrives during a CPU BUSY cycle
    b2.cpu_req = 1; b2.cpu_addr = 16'h0040;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) begin
        b2.io_req = 1; b2.io_addr = 16'h0050;
      end
      no_overlap();
      chk($sformatf("t4_rd%0d", i), 32'(b2.mem_read),
          32'(i == 1 || i == 2 || i == 5 || i == 6));
      chk($sformatf("t4_cack%0d", i), 32'(b2.cpu_ack), 32'(i == 3));
      chk($sformatf("t4_iack%0d", i), 32'(b2.io_ack), 32'(i == 7));
      if (i == 3) begin
        chk("t4_crd", 32'(b2.cpu_rdata), 32'h5A1A);
        b2.cpu_req = 0;
      end
      if (i == 5) chk("t4_addr", 32'(b2.mem_addr), 32'h0050);
      if (i == 7) begin
        chk("t4_ird", 32'(b2.io_rdata), 32'h5A0A);
        b2.io_req = 0;
      end
    end

    // reset in the middle of a CPU write
    b2.cpu_req = 1; b2.cpu_we = 1;
    b2.cpu_addr = 16'h0077; b2.cpu_wdata = 16'hBEEF;
    step();
    chk("t5_wr", 32'(b2.mem_write), 1);
    reset = 1'b1;
    b2.cpu_req = 0; b2.cpu_we = 0;
    step();
    chk_zero("t5");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_noack", 32'(b2.cpu_ack), 0);
    end
    b2.cpu_req = 1; b2.cpu_addr = 16'h3000;
    b2.io_req  = 1; b2.io_addr  = 16'h0060;
    step();
    chk("t5_gio", 32'(b2.grant_io), 0);
    chk("t5_addr", 32'(b2.mem_addr), 32'h3000);
    step();
    step();
    chk("t5_cack", 32'(b2.cpu_ack), 1);
    chk("t5_iack", 32'(b2.io_ack), 0);
    chk("t5_crd", 32'(b2.cpu_rdata), 32'h1234);
    b2.cpu_req = 0; b2.io_req = 0;
    step();

    // MEM_LAT = 1 instance
    b1.cpu_req = 1; b1.cpu_addr = 16'h3000;
    step();
    chk("t6_rd1", 32'(b1.mem_read), 1);
    chk("t6_ack1", 32'(b1.cpu_ack), 0);
    step();
    chk("t6_rd2", 32'(b1.mem_read), 0);
    chk("t6_ack2", 32'(b1.cpu_ack), 1);
    chk("t6_crd", 32'(b1.cpu_rdata), 32'h1234);
    b1.cpu_req = 0;
    step();
    chk("t6_ack3", 32'(b1.cpu_ack), 0);
    chk("t6_rd3", 32'(b1.mem_read), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and access sequencer that shares the single LC-3 RAM between the CPU datapath port (MAR/MDR fetch, load, store) and an I/O port (console/DMA agent). It accepts request/acknowledge transactions from each side and grants them round-robin. For each granted transaction it drives the RAM read/write strobes for a fixed latency and returns read data to the winning port. It sits between the control FSM/MDR logic and the RAM instance in the top-level LC-3 module.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles the RAM strobe must be held per access (legal range 1..15)

- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  last CPU read result
- io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  I/O port request; same rules as the CPU port
- io_ack  out  1  one-cycle completion pulse
- io_rdata  out  DATA_W  last I/O read result
- mem_read  out  1  RAM read strobe
- mem_write  out  1  RAM write strobe
- mem_addr  out  ADDR_W  latched RAM address
- mem_wdata  out  DATA_W  latched RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid in the last strobe cycle
- grant_io  out  1  1 while the current or last transaction belongs to the I/O port

## Operation
- FSM states:
  - IDLE → BUSY on any sampled request.
  - BUSY → RESP after MEM_LAT cycles.
  - RESP → IDLE unconditionally.
- Arbitration happens in IDLE only.
  - Only one request pending: grant it.
  - Both pending: grant the port not granted last.
  - Last-winner pointer resets to "I/O", so the CPU wins the first tie.
  - Pointer updates on each grant.
- On grant: latch we/addr/wdata of the winner into mem_addr/mem_wdata and an internal we bit; set grant_io; load the down-counter with MEM_LAT-1.
- BUSY:
  - mem_read = !we or mem_write = we, asserted every BUSY cycle.
  - Counter decrements each cycle.
  - At the cycle with counter = 0 and we = 0, register mem_rdata into the winner's rdata register.
- RESP:
  - Strobes low.
  - Winner's ack = 1 for exactly this cycle; the loser's ack stays 0.
- Each rdata register changes only on its own port's read completion. Writes never alter either rdata register.
- A requester deasserts req on the cycle after ack. A req still high in the IDLE cycle after RESP is treated as a new transaction.
- Requests arriving during BUSY/RESP are not lost: req is level-held and is sampled in the next IDLE.
- Reset (any state):
  - state = IDLE, all outputs 0 (acks, strobes, mem_addr, mem_wdata, both rdata, grant_io).
  - Pointer reset to I/O.
  - An in-flight transaction is aborted with no ack. A write may be partial; requesters must reissue.

## Timing
- Request sampled high in IDLE at edge k:
  - BUSY cycles k+1..k+MEM_LAT, with the strobe high exactly MEM_LAT cycles.
  - ack high in cycle k+MEM_LAT+1; rdata valid from that same cycle.
- Service period for back-to-back requests: MEM_LAT+2 cycles per transaction.
- All outputs are registered. There is no combinational path from req to ack or to the strobes.
- mem_read and mem_write are never high in the same cycle. Neither is high outside BUSY.
- cpu_ack and io_ack are never high in the same cycle.

## Test plan
- CPU read, MEM_LAT=2: cpu_req=1, cpu_we=0, cpu_addr=16'h3000, RAM returns 16'h1234 → mem_read high 2 cycles with mem_addr=16'h3000; cpu_ack pulses 3 cycles after the sampling edge; cpu_rdata=16'h1234; io_ack stays 0.
- I/O write: io_we=1, io_addr=16'hFE06, io_wdata=16'h0041 → mem_write high 2 cycles with matching addr/data; io_ack pulses once; io_rdata and cpu_rdata unchanged.
- Tie after reset: cpu_req and io_req held continuously → grant order CPU, I/O, CPU, I/O; acks 4 cycles apart; grant_io toggles each transaction.
- Late arrival: io_req rises during a CPU BUSY cycle → CPU completes, then I/O is granted in the following IDLE without loss; no overlap of strobes.
- Reset mid-BUSY on a CPU write → next cycle all outputs 0, no cpu_ack; a fresh CPU request afterwards completes normally and wins a tie.
- MEM_LAT=1 sweep: single read → strobe high exactly 1 cycle, ack 2 cycles after sampling, correct rdata captured.
